decoder_scan_ctrl: RTL and testbench

Sequential scan controller sitting directly upstream of `decoder_3_8`. It drives the decoder's 3-bit select `a` and enable `en` to walk the eight output lines in ascending order. It skips masked-off lines, holds each line active for a programmable dwell time and inserts a one-cycle break-before-make gap between lines. Typical consumers are row/column scanners for LED matrices and keypads.

---
 rtl/decoder_scan_pkg.sv | 19 +
 rtl/decoder_3_8.sv | 21 ++
 rtl/decoder_scan_ctrl_mask_next_idx.sv | 37 +++
 rtl/decoder_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_pkg
// Brief    : Shared sizes and FSM state type for the decoder scan controller.
// Revision : 1.0
// ============================================================================
package decoder_scan_pkg;

    localparam int N_LINES = 8;
    localparam int ADDR_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_3_8.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3_8
// Brief    : 3-to-8 one-hot decoder with active-high enable.
// Revision : 1.0
// ============================================================================
module decoder_3_8 (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            out[a] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_ctrl_mask_next_idx.sv
`default_nettype none
// ============================================================================
// Module   : mask_next_idx
// Brief    : Finds the lowest set mask bit overall and the lowest above cur.
// Revision : 1.0
// ============================================================================
module mask_next_idx
    import decoder_scan_pkg::*;
(
    input  logic [N_LINES-1:0] mask,
    input  logic [ADDR_W-1:0]  cur,
    output logic               found_above,
    output logic [ADDR_W-1:0]  idx_above,
    output logic               any,
    output logic [ADDR_W-1:0]  idx_low
);

    // Descending walk so the last hit written is the lowest qualifying index.
    always_comb begin
        found_above = 1'b0;
        idx_above   = '0;
        any         = 1'b0;
        idx_low     = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                any     = 1'b1;
                idx_low = ADDR_W'(i);
                if (i > int'(cur)) begin
                    found_above = 1'b1;
                    idx_above   = ADDR_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_ctrl
// Brief    : Walks decoder_3_8 lines in ascending order with dwell and gap.
// Revision : 1.0
// ============================================================================
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [N_LINES-1:0] mask,
    output logic [ADDR_W-1:0]  a,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam logic [7:0] c_DWELL_LOAD = 8'(DWELL - 1);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic [N_LINES-1:0] r_mask_q;
    logic [N_LINES-1:0] w_mask_nxt;
    logic               r_cont_q;
    logic               w_cont_nxt;
    logic [ADDR_W-1:0]  w_a_nxt;
    logic               w_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_q_found;
    logic [ADDR_W-1:0]  w_q_above;
    logic               w_q_any_unused;
    logic [ADDR_W-1:0]  w_q_low_unused;
    logic               w_in_found_unused;
    logic [ADDR_W-1:0]  w_in_above_unused;
    logic               w_in_any;
    logic [ADDR_W-1:0]  w_in_low;

    // Next line inside the latched sweep mask.
    mask_next_idx u_next_q (
        .mask        (r_mask_q),
        .cur         (a),
        .found_above (w_q_found),
        .idx_above   (w_q_above),
        .any         (w_q_any_unused),
        .idx_low     (w_q_low_unused)
    );

    // First line of the live mask, used at start and at every wrap.
    mask_next_idx u_next_in (
        .mask        (mask),
        .cur         ('0),
        .found_above (w_in_found_unused),
        .idx_above   (w_in_above_unused),
        .any         (w_in_any),
        .idx_low     (w_in_low)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mask_q <= '0;
            r_cont_q <= 1'b0;
            a        <= '0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mask_q <= w_mask_nxt;
            r_cont_q <= w_cont_nxt;
            a        <= w_a_nxt;
            en       <= w_en_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask_q;
        w_cont_nxt  = r_cont_q;
        w_a_nxt     = a;
        w_en_nxt    = en;
        w_done_nxt  = 1'b0;

        if (stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_a_nxt     = '0;
            w_en_nxt    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    w_a_nxt   = '0;
                    w_en_nxt  = 1'b0;
                    if (start) begin
                        if (w_in_any) begin
                            w_mask_nxt  = mask;
                            w_cont_nxt  = cont;
                            w_state_nxt = ON;
                            w_a_nxt     = w_in_low;
                            w_en_nxt    = 1'b1;
                            w_cnt_nxt   = c_DWELL_LOAD;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                ON: begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end else if (w_q_found) begin
                        w_state_nxt = GAP;
                        w_a_nxt     = w_q_above;
                        w_en_nxt    = 1'b0;
                    end else if (r_cont_q && w_in_any) begin
                        w_mask_nxt  = mask;
                        w_state_nxt = GAP;
                        w_a_nxt     = w_in_low;
                        w_en_nxt    = 1'b0;
                    end else begin
                        // Sweep finished, or a wrap resampled an empty mask.
                        if (r_cont_q) begin
                            w_mask_nxt = mask;
                        end
                        w_state_nxt = IDLE;
                        w_a_nxt     = '0;
                        w_en_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                GAP: begin
                    w_state_nxt = ON;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = c_DWELL_LOAD;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_a_nxt     = '0;
                    w_en_nxt    = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_ctrl
// Brief    : Randomised scoreboard bench for decoder_scan_ctrl + decoder_3_8.
// Revision : 1.0
// ============================================================================
module tb_decoder_scan_ctrl;

    typedef struct {
        logic [2:0] a;
        logic       en;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, stop0, cont0;
    logic [7:0] mask0;
    logic [2:0] a0;
    logic       en0, busy0, done0;
    logic [7:0] out0;

    logic       rst1, start1, stop1, cont1;
    logic [7:0] mask1;
    logic [2:0] a1;
    logic       en1, busy1, done1;
    logic [7:0] out1;

    decoder_scan_ctrl #(.DWELL(4)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .stop(stop0), .cont(cont0),
        .mask(mask0), .a(a0), .en(en0), .busy(busy0), .done(done0)
    );
    decoder_3_8 u_dec0 (.a(a0), .en(en0), .out(out0));

    decoder_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .stop(stop1), .cont(cont1),
        .mask(mask1), .a(a1), .en(en1), .busy(busy1), .done(done1)
    );
    decoder_3_8 u_dec1 (.a(a1), .en(en1), .out(out1));

    int total = 0;
    int bad   = 0;

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    exp_t       trace[$];
    int         tags[$];
    logic [7:0] sweeps[$];

    function automatic exp_t mk(input int a, input bit en, input bit busy, input bit done);
        exp_t e;
        e.a    = 3'(a);
        e.en   = en;
        e.busy = busy;
        e.done = done;
        return e;
    endfunction

    task automatic cmp(input int inst, input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, inst, $time, got, want);
        end
    endtask

    task automatic check(input int inst, input exp_t e, input logic [2:0] ga, input logic gen,
                         input logic gbusy, input logic gdone, input logic [7:0] gout);
        logic [7:0] eout;
        eout = e.en ? (8'd1 << e.a) : 8'd0;
        cmp(inst, "a",    {5'd0, ga},    {5'd0, e.a});
        cmp(inst, "en",   {7'd0, gen},   {7'd0, e.en});
        cmp(inst, "busy", {7'd0, gbusy}, {7'd0, e.busy});
        cmp(inst, "done", {7'd0, gdone}, {7'd0, e.done});
        cmp(inst, "out",  gout,          eout);
    endtask

    // Monitor: one expected entry per cycle while a run is outstanding.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check(0, e, a0, en0, busy0, done0, out0);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check(1, e, a1, en1, busy1, done1, out1);
        end
    end

    // Reference trace: entry k is the output seen in the cycle after edge k,
    // where edge 0 is the one that samples start. Lines ascend per sweep,
    // each held dw cycles, with one gap cycle before every line but the first.
    task automatic build_trace(input bit c, input int dw);
        int         s;
        bit         first;
        bit         fin;
        logic [7:0] m;
        trace.delete();
        tags.delete();
        s     = 0;
        first = 1'b1;
        fin   = 1'b0;
        while (!fin) begin
            m = sweeps[s];
            if (m == 8'h00) begin
                trace.push_back(mk(0, 0, 0, 1));
                tags.push_back(s);
                fin = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (m[i]) begin
                        if (!first) begin
                            trace.push_back(mk(i, 0, 1, 0));
                            tags.push_back(s);
                        end
                        first = 1'b0;
                        for (int d = 0; d < dw; d++) begin
                            trace.push_back(mk(i, 1, 1, 0));
                            tags.push_back(s);
                        end
                    end
                end
                if (!c) begin
                    trace.push_back(mk(0, 0, 0, 1));
                    tags.push_back(s);
                    fin = 1'b1;
                end else if (s + 1 >= sweeps.size()) begin
                    fin = 1'b1;
                end else begin
                    s++;
                end
            end
        end
    endtask

    task automatic drive(input int inst, input logic st, input logic [7:0] m, input logic ct,
                         input logic sp, input logic rs);
        if (inst == 0) begin
            start0 = st; mask0 = m; cont0 = ct; stop0 = sp; rst0 = rs;
        end else begin
            start1 = st; mask1 = m; cont1 = ct; stop1 = sp; rst1 = rs;
        end
    endtask

    task automatic do_run(input int inst, input bit c, input int stop_at, input int rst_at, input bit noisy);
        exp_t       tr[$];
        int         cut;
        logic       st;
        logic [7:0] m;
        tr  = trace;
        cut = -1;
        if (stop_at >= 0) cut = stop_at;
        if (rst_at >= 0 && (cut < 0 || rst_at < cut)) cut = rst_at;
        if (cut >= 0 && cut < tr.size()) begin
            while (tr.size() > cut) void'(tr.pop_back());
            tr.push_back(mk(0, 0, 0, 0));
        end
        tr.push_back(mk(0, 0, 0, 0));
        tr.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        foreach (tr[i]) begin
            if (inst == 0) exp_q0.push_back(tr[i]);
            else           exp_q1.push_back(tr[i]);
        end
        for (int k = 0; k < tr.size(); k++) begin
            if (k > 0) @(negedge clk);
            st = (k == 0) || (noisy && tr[k-1].busy && ($urandom_range(0, 3) == 0));
            if (k == 0)
                m = sweeps[0];
            else if (c && (k - 1) < tags.size() && (tags[k-1] + 1) < sweeps.size())
                m = sweeps[tags[k-1] + 1];
            else
                m = 8'($urandom);
            drive(inst, st, m, (k == 0) ? c : 1'($urandom), (k == stop_at), (k == rst_at));
        end
    endtask

    initial begin
        int idx;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q0.push_back(mk(0, 0, 0, 0));
            exp_q1.push_back(mk(0, 0, 0, 0));
        end
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Full single sweep and sparse mask
        sweeps = '{8'hFF};
        build_trace(1'b0, 4);
        do_run(0, 1'b0, -1, -1, 1'b0);
        sweeps = '{8'hA4};
        build_trace(1'b0, 4);
        do_run(0, 1'b0, -1, -1, 1'b0);

        // Continuous wrap with remask, ended by stop
        sweeps = '{8'h81, 8'h10, 8'h10, 8'h10, 8'h10};
        build_trace(1'b1, 4);
        do_run(0, 1'b1, trace.size() - 2, -1, 1'b0);

        // Stop during the second dwell cycle of line 3, then restart
        sweeps = '{8'hFF};
        build_trace(1'b0, 4);
        idx = -1;
        foreach (trace[i]) if (idx < 0 && trace[i].en && trace[i].a == 3'd3) idx = i;
        do_run(0, 1'b0, idx + 2, -1, 1'b0);
        sweeps = '{8'h58};
        build_trace(1'b0, 4);
        do_run(0, 1'b0, -1, -1, 1'b0);

        // Zero mask, then starts pulsed while busy
        sweeps = '{8'h00};
        build_trace(1'b0, 4);
        do_run(0, 1'b0, -1, -1, 1'b0);
        sweeps = '{8'hFF};
        build_trace(1'b0, 4);
        do_run(0, 1'b0, -1, -1, 1'b1);

        // Reset during the first gap
        sweeps = '{8'h0C};
        build_trace(1'b0, 4);
        idx = -1;
        foreach (trace[i]) if (idx < 0 && !trace[i].en && trace[i].busy) idx = i;
        do_run(0, 1'b0, -1, idx + 1, 1'b0);

        // DWELL=1 instance
        sweeps = '{8'h03};
        build_trace(1'b0, 1);
        do_run(1, 1'b0, -1, -1, 1'b0);
        sweeps = '{8'h01, 8'h01, 8'h00};
        build_trace(1'b1, 1);
        do_run(1, 1'b1, -1, -1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            int         inst;
            bit         c;
            int         n;
            int         sp;
            logic [7:0] m;
            inst = int'($urandom_range(0, 1));
            c    = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 3));
            sweeps.delete();
            for (int j = 0; j < n; j++) begin
                m = 8'($urandom);
                if ($urandom_range(0, 7) == 0) m = 8'h00;
                sweeps.push_back(m);
            end
            if (c) sweeps.push_back(8'h00);
            build_trace(c, (inst == 0) ? 4 : 1);
            sp = -1;
            if ($urandom_range(0, 3) == 0 && trace.size() > 2)
                sp = int'($urandom_range(1, trace.size() - 1));
            do_run(inst, c, sp, -1, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", exp_q0.size(), exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
